// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3
// Latches 8 request lines into a sticky pending mask and issues one pending
// index at a time over a valid/ready handshake. Selection is round-robin
// starting from a rotating pointer; the pointer advances past each accepted
// index so that no requester can starve another.
//
// Build option:
//   ENC_FIXED_PRIO_EN - when defined, the lowest pending index always wins
//                       (classic priority encoder); the pointer register is
//                       not built and RST_PTR has no effect.
//
// Downstream, out_idx/out_valid drive the 3-to-8 decoder's in/EN so that
// every accepted index becomes a one-hot strobe.

module req_encoder_8to3 #(
    parameter int unsigned           N_REQ   = 8,
    parameter int unsigned           IDX_W   = 3,
    parameter logic [IDX_W-1:0]      RST_PTR = 3'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pend,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pend_next;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             accept;

    assign accept = out_valid & out_ready;

    // One-hot clear of the index being handed off this cycle
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[out_idx] = 1'b1;
        end
    end

    // New requests are OR-ed in after the clear, so a re-request of the
    // accepted bit in the same cycle keeps it pending
    always_comb begin
        pend_next = pend & ~clr;
        if (EN) begin
            pend_next = pend_next | req;
        end
    end

`ifdef ENC_FIXED_PRIO_EN

    // Lowest pending index wins
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!sel_found && pend[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Scan ptr, ptr+1, ... modulo 8; first pending index wins.
    // The IDX_W-bit addition provides the modulo wrap for free.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!sel_found && pend[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Pointer moves just past each accepted index (7 wraps to 0)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= RST_PTR;
        end else if (state == HOLD && out_ready) begin
            ptr <= out_idx + 1'b1;
        end
    end

`endif

    // Pending mask register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Handshake FSM: IDLE loads the selected index, HOLD keeps it stable
    // until the consumer takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_idx   <= sel_idx;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Work outstanding: something pending or an index on offer
    assign busy = (pend != '0) | out_valid;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Testbench for req_encoder_8to3: table-driven directed vectors, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.

module tb_req_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       EN;
    logic [7:0] req;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pend;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    req_encoder_8to3 #(.N_REQ(8), .IDX_W(3), .RST_PTR(3'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pend      (pend),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] req;
        logic       rdy;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs, clock one edge, sample 1 time unit later
    task automatic tick(input logic r, input logic e, input logic [7:0] q, input logic y);
        rst_n     = r;
        EN        = e;
        req       = q;
        out_ready = y;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [7:0] q, input logic y,
                       input logic v, input logic [2:0] i, input logic [7:0] p);
        vec_t t;
        t.rst_n = r; t.en = e; t.req = q; t.rdy = y;
        t.valid = v; t.idx = i; t.pend = p; t.busy = (p != 8'h00) || v;
        vecs.push_back(t);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_pend;
    bit         m_valid;
    int         m_idx;
    int         m_ptr;

    function automatic int pick(input logic [7:0] p, input int ptr);
        int j;
        for (int k = 0; k < 8; k++) begin
`ifdef ENC_FIXED_PRIO_EN
            j = k;
`else
            j = (ptr + k) % 8;
`endif
            if (p[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [7:0] q, input logic y);
        logic [7:0] np;
        if (!r) begin
            m_pend = 8'h00; m_valid = 0; m_idx = 0; m_ptr = 0;
        end else begin
            np = m_pend;
            if (m_valid && y) np[m_idx] = 1'b0;
            if (e) np = np | q;
            if (!m_valid) begin
                if (m_pend != 8'h00) begin
                    m_idx   = pick(m_pend, m_ptr);
                    m_valid = 1;
                end
            end else if (y) begin
                m_valid = 0;
                m_ptr   = (m_idx + 1) % 8;
            end
            m_pend = np;
        end
    endtask

    initial begin
        logic [7:0] p;
        logic       r, e, y;
        logic [7:0] q;
        bit         hi_seen;

        rst_n = 1'b0; EN = 1'b0; req = 8'h00; out_ready = 1'b0;

        // ---- directed table ----
        // reset then idle
        add(0,0,8'h00,0, 0,0,8'h00);
        add(0,0,8'h00,0, 0,0,8'h00);
        for (int i = 0; i < 10; i++) add(1,1,8'h00,1, 0,0,8'h00);
        // single request, immediate accept
        add(1,1,8'h20,1, 0,0,8'h20);
        add(1,1,8'h00,1, 1,5,8'h20);
        add(1,1,8'h00,1, 0,5,8'h00);
        add(1,1,8'h00,1, 0,5,8'h00);
        // single request, 4 cycles of backpressure
        add(1,1,8'h20,0, 0,5,8'h20);
        add(1,1,8'h00,0, 1,5,8'h20);
        for (int i = 0; i < 4; i++) add(1,1,8'h00,0, 1,5,8'h20);
        add(1,1,8'h00,1, 0,5,8'h00);
        // reset so the pointer is back at 0, then all eight request
        add(0,1,8'h00,1, 0,0,8'h00);
        add(1,1,8'hFF,1, 0,0,8'hFF);
        p = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            add(1,1,8'h00,1, 1,3'(k),p);
            p = p << 1;
            add(1,1,8'h00,1, 0,3'(k),p);
        end
        // 0 then 7 once the pointer has wrapped to 0
        add(1,1,8'h81,1, 0,7,8'h81);
        add(1,1,8'h00,1, 1,0,8'h81);
        add(1,1,8'h00,1, 0,0,8'h80);
        add(1,1,8'h00,1, 1,7,8'h80);
        add(1,1,8'h00,1, 0,7,8'h00);

        foreach (vecs[n]) begin
            tick(vecs[n].rst_n, vecs[n].en, vecs[n].req, vecs[n].rdy);
            check($sformatf("tbl%0d.valid", n), int'(out_valid), int'(vecs[n].valid));
            check($sformatf("tbl%0d.idx",   n), int'(out_idx),   int'(vecs[n].idx));
            check($sformatf("tbl%0d.pend",  n), int'(pend),      int'(vecs[n].pend));
            check($sformatf("tbl%0d.busy",  n), int'(busy),      int'(vecs[n].busy));
        end

        // ---- set beats clear: req[3] held high through its own acceptance ----
        tick(0,1,8'h00,1);
        tick(1,1,8'h08,1);
        check("sbc.pend0", int'(pend), 8'h08);
        tick(1,1,8'h08,1);
        check("sbc.valid0", int'(out_valid), 1);
        check("sbc.idx0", int'(out_idx), 3);
        tick(1,1,8'h08,1);
        check("sbc.pend_kept", int'(pend), 8'h08);
        check("sbc.valid_drop", int'(out_valid), 0);
        tick(1,1,8'h08,1);
        check("sbc.reissue", int'(out_valid), 1);
        check("sbc.idx1", int'(out_idx), 3);

`ifndef ENC_FIXED_PRIO_EN
        // ---- no starvation: 0 and 5 held high alternate ----
        tick(0,1,8'h00,1);
        tick(1,1,8'h21,1);
        for (int k = 0; k < 4; k++) begin
            tick(1,1,8'h21,1);
            check($sformatf("rr.valid%0d", k), int'(out_valid), 1);
            check($sformatf("rr.idx%0d", k), int'(out_idx), (k % 2 == 0) ? 0 : 5);
            tick(1,1,8'h21,1);
        end
`endif

        // ---- EN gating: only 2 then 3 issue, 4..7 never pend ----
        tick(0,1,8'h00,1);
        tick(1,1,8'h0C,1);
        hi_seen = 0;
        tick(1,0,8'hF0,1);
        if (pend[7:4] != 4'h0) hi_seen = 1;
        check("en.idx2", int'(out_idx), 2);
        check("en.v2", int'(out_valid), 1);
        tick(1,0,8'hF0,1);
        if (pend[7:4] != 4'h0) hi_seen = 1;
        tick(1,0,8'hF0,1);
        if (pend[7:4] != 4'h0) hi_seen = 1;
        check("en.idx3", int'(out_idx), 3);
        check("en.v3", int'(out_valid), 1);
        tick(1,0,8'hF0,1);
        if (pend[7:4] != 4'h0) hi_seen = 1;
        tick(1,0,8'hF0,1);
        check("en.no_high", int'(hi_seen), 0);
        check("en.drained", int'(busy), 0);

        // ---- reset while in HOLD, with a handshake in the same cycle ----
        tick(1,1,8'h10,0);
        tick(1,1,8'h00,0);
        check("rst.hold", int'(out_valid), 1);
        check("rst.hold_idx", int'(out_idx), 4);
        tick(0,1,8'h10,1);
        check("rst.valid", int'(out_valid), 0);
        check("rst.pend", int'(pend), 0);
        check("rst.idx", int'(out_idx), 0);
        tick(1,1,8'hFF,1);
        tick(1,1,8'h00,1);
        check("rst.ptr_first", int'(out_idx), 0);

`ifdef ENC_FIXED_PRIO_EN
        // ---- fixed priority: 2 always beats 7 ----
        tick(0,1,8'h00,1);
        tick(1,1,8'h84,1);
        for (int k = 0; k < 3; k++) begin
            tick(1,1,8'h84,1);
            check($sformatf("fp.idx%0d", k), int'(out_idx), 2);
            tick(1,1,8'h84,1);
        end
`endif

        // ---- randomized traffic against the reference model ----
        model_step(0,0,8'h00,0);
        tick(0,0,8'h00,0);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0,99) != 0);
            e = ($urandom_range(0,3) != 0);
            q = ($urandom_range(0,2) == 0) ? 8'($urandom) : 8'h00;
            y = ($urandom_range(0,2) != 0);
            model_step(r, e, q, y);
            tick(r, e, q, y);
            check("rnd.valid", int'(out_valid), int'(m_valid));
            check("rnd.idx",   int'(out_idx),   m_idx);
            check("rnd.pend",  int'(pend),      int'(m_pend));
            check("rnd.busy",  int'(busy),      int'((m_pend != 8'h00) || m_valid));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
